// File: rtl/lru_single_if.sv
// Access-port bundle between the replacement-state controller and one way's age cell.
interface lru_single_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] lru;
    logic [WIDTH-1:0] hitLRU;
    logic             init;
    logic             en;
    logic [WIDTH-1:0] newLRU;
    logic             victim;

    modport master (
        output lru,
        output hitLRU,
        output init,
        output en,
        input  newLRU,
        input  victim
    );

    modport slave (
        input  lru,
        input  hitLRU,
        input  init,
        input  en,
        output newLRU,
        output victim
    );
endinterface

// File: rtl/lru_single.sv
// Per-way age-rank update cell. Age 0 is MRU and the all-ones age marks the
// replacement victim. State changes on the falling edge of clk.
module lru_single #(
    parameter int WIDTH = 3,
    parameter int INDEX = 0
) (
    input  logic          clk,
    input  logic          rst,
    lru_single_if.slave   bus
);
    localparam logic [WIDTH-1:0] INDEX_AGE = WIDTH'(INDEX);
    localparam logic [WIDTH-1:0] OLDEST    = '1;

    logic [WIDTH-1:0] next_age;

    // Next age: init restores the way's own index; an access moves the hit way
    // to MRU and ages every younger way by one. lru < hitLRU guarantees the
    // increment never wraps.
    always_comb begin
        next_age = bus.newLRU;
        if (bus.init) begin
            next_age = INDEX_AGE;
        end else if (bus.en) begin
            if (bus.lru == bus.hitLRU) begin
                next_age = '0;
            end else if (bus.lru < bus.hitLRU) begin
                next_age = bus.lru + 1'b1;
            end else begin
                next_age = bus.lru;
            end
        end
    end

    // Register the age and derive victim from the same value being stored.
    always_ff @(negedge clk) begin
        if (rst) begin
            bus.newLRU <= INDEX_AGE;
            bus.victim <= (INDEX_AGE == OLDEST);
        end else begin
            bus.newLRU <= next_age;
            bus.victim <= (next_age == OLDEST);
        end
    end
endmodule

// File: tb/tb_lru_single.sv
// Bench for lru_single: directed single-cell steps, then a full 8-way set
// checked against a recency-ordered list of ways.
module tb_lru_single;
    localparam int W = 3;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W-1:0] lru_drv [N];
    logic [W-1:0] hit_drv [N];
    logic         init_drv[N];
    logic         en_drv  [N];
    logic [W-1:0] new_obs [N];
    logic         vic_obs [N];

    lru_single_if #(.WIDTH(W)) bus [N] ();

    for (genvar g = 0; g < N; g++) begin : g_way
        assign bus[g].lru    = lru_drv[g];
        assign bus[g].hitLRU = hit_drv[g];
        assign bus[g].init   = init_drv[g];
        assign bus[g].en     = en_drv[g];
        assign new_obs[g]    = bus[g].newLRU;
        assign vic_obs[g]    = bus[g].victim;
        lru_single #(.WIDTH(W), .INDEX(g)) u_cell (
            .clk (clk),
            .rst (rst),
            .bus (bus[g])
        );
    end

    int checks = 0;
    int errors = 0;
    int order[$];   // ways listed from most to least recently used

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            lru_drv[i]  = '0;
            hit_drv[i]  = '0;
            init_drv[i] = 1'b0;
            en_drv[i]   = 1'b0;
        end
    endtask

    function automatic int age_of(input int way);
        for (int k = 0; k < order.size(); k++)
            if (order[k] == way) return k;
        return -1;
    endfunction

    initial begin
        idle_all();
        rst = 1'b1;
        tick();
        chk("rst_new_idx2", int'(new_obs[2]), 2);
        chk("rst_vic_idx2", int'(vic_obs[2]), 0);
        chk("rst_new_idx7", int'(new_obs[7]), 7);
        chk("rst_vic_idx7", int'(vic_obs[7]), 1);
        rst = 1'b0;

        lru_drv[2] = 3'd5; hit_drv[2] = 3'd5; en_drv[2] = 1'b1;
        tick();
        chk("hit_self_new", int'(new_obs[2]), 0);
        chk("hit_self_vic", int'(vic_obs[2]), 0);

        lru_drv[2] = 3'd3; hit_drv[2] = 3'd5;
        tick();
        chk("aging_new", int'(new_obs[2]), 4);

        lru_drv[2] = 3'd6; hit_drv[2] = 3'd5;
        tick();
        chk("older_new", int'(new_obs[2]), 6);

        lru_drv[2] = 3'd6; hit_drv[2] = 3'd7;
        tick();
        chk("victim_age_new", int'(new_obs[2]), 7);
        chk("victim_age_vic", int'(vic_obs[2]), 1);

        lru_drv[2] = 3'd3; hit_drv[2] = 3'd3; init_drv[2] = 1'b1;
        tick();
        chk("init_over_en", int'(new_obs[2]), 2);
        chk("init_vic", int'(vic_obs[2]), 0);

        init_drv[2] = 1'b0; en_drv[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lru_drv[2] = W'(i * 3 + 1);
            hit_drv[2] = W'(i * 3 + 1);
            tick();
            chk("hold_new", int'(new_obs[2]), 2);
        end

        lru_drv[2] = 3'd6; hit_drv[2] = 3'd7; en_drv[2] = 1'b1;
        tick();
        chk("pre_rst_new", int'(new_obs[2]), 7);
        rst = 1'b1; lru_drv[2] = 3'd5; hit_drv[2] = 3'd5;
        tick();
        chk("rst_over_en", int'(new_obs[2]), 2);
        chk("rst_over_en_vic", int'(vic_obs[2]), 0);
        rst = 1'b0;

        // Whole set: init, then random accesses with feedback.
        idle_all();
        for (int i = 0; i < N; i++) init_drv[i] = 1'b1;
        tick();
        order = {};
        for (int i = 0; i < N; i++) order.push_back(i);
        for (int i = 0; i < N; i++) chk("set_init", int'(new_obs[i]), i);
        for (int i = 0; i < N; i++) init_drv[i] = 1'b0;

        for (int c = 0; c < 1000; c++) begin
            int way;
            int hit;
            int pos;
            int mask;
            int nvic;
            way = int'($urandom_range(0, N - 1));
            hit = age_of(way);
            for (int i = 0; i < N; i++) begin
                lru_drv[i] = new_obs[i];
                hit_drv[i] = W'(hit);
                en_drv[i]  = 1'b1;
            end
            tick();
            pos = age_of(way);
            order.delete(pos);
            order.push_front(way);
            mask = 0;
            nvic = 0;
            for (int i = 0; i < N; i++) begin
                chk("set_age", int'(new_obs[i]), age_of(i));
                mask = mask | (1 << int'(new_obs[i]));
                nvic = nvic + int'(vic_obs[i]);
            end
            chk("set_distinct", mask, 255);
            chk("set_one_victim", nvic, 1);
            chk("set_hit_mru", int'(new_obs[way]), 0);
        end

        idle_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
